// File: rtl/calc_engine.sv
// rtl/calc_engine.sv - arithmetic stage after the UART command parser: + - * / with valid/ready result
module calc_engine #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [3:0]      dtype,
  input  logic [4:0]      operator,
  input  logic [DW-1:0]   src1,
  input  logic [DW-1:0]   src2,
  input  logic            parser_done,
  input  logic            res_ready,
  output logic            res_valid,
  output logic [2*DW-1:0] result,
  output logic [1:0]      res_err,
  output logic            busy
);

  localparam int RW = 2 * DW;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [3:0] DT_S = 4'h1;
  localparam logic [3:0] DT_U = 4'h2;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_DIV0  = 2'b01;
  localparam logic [1:0] ERR_OP    = 2'b10;
  localparam logic [1:0] ERR_DTYPE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  // parser_done delay used to detect its rising edge
  logic pd_q;
  logic start;

  // operation captured on start; later input changes cannot disturb it
  logic [3:0]    dtype_q;
  logic [4:0]    op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  // restoring divider state: partial remainder, dividend/quotient shift register, divisor
  logic [DW-1:0] div_rem;
  logic [DW-1:0] div_quo;
  logic [DW-1:0] div_dvs;
  logic [CW-1:0] div_cnt;
  logic          div_neg_q;
  logic          div_neg_r;

  // combinational helpers
  logic          is_signed;
  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic          a_neg;
  logic          b_neg;
  logic [DW-1:0] a_abs;
  logic [DW-1:0] b_abs;
  logic [1:0]    err_code;
  logic [RW-1:0] alu_res;
  logic [DW:0]   div_shift;
  logic [DW:0]   div_diff;
  logic          div_bit;
  logic [DW-1:0] rem_nxt;
  logic [DW-1:0] quo_nxt;
  logic [DW-1:0] q_fin;
  logic [DW-1:0] r_fin;

  assign start = parser_done & ~pd_q;

  // operand extension, magnitudes for the divider and the error code for the captured op
  always_comb begin
    is_signed = (dtype_q == DT_S);
    a_ext     = is_signed ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
    b_ext     = is_signed ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
    a_neg     = is_signed & a_q[DW-1];
    b_neg     = is_signed & b_q[DW-1];
    a_abs     = a_neg ? -a_q : a_q;
    b_abs     = b_neg ? -b_q : b_q;

    // priority: bad dtype over bad operator over divide-by-zero
    err_code = ERR_OK;
    if ((dtype_q != DT_S) && (dtype_q != DT_U)) begin
      err_code = ERR_DTYPE;
    end else if ((op_q < OP_ADD) || (op_q > OP_DIV)) begin
      err_code = ERR_OP;
    end else if ((op_q == OP_DIV) && (b_q == '0)) begin
      err_code = ERR_DIV0;
    end
  end

  // single-cycle add/sub/mul; the low 2*DW bits of the extended product are exact for both signednesses
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MUL:  alu_res = a_ext * b_ext;
      default: alu_res = '0;
    endcase
  end

  // one restoring-division step: shift in the next dividend bit and try to subtract the divisor
  always_comb begin
    div_shift = {div_rem, div_quo[DW-1]};
    div_diff  = div_shift - {1'b0, div_dvs};
    div_bit   = ~div_diff[DW];
    // a failed trial leaves div_shift below the divisor, so its top bit is zero
    rem_nxt   = div_bit ? div_diff[DW-1:0] : div_shift[DW-1:0];
    quo_nxt   = {div_quo[DW-2:0], div_bit};
    // truncating division: quotient sign from both operands, remainder follows the dividend
    q_fin     = div_neg_q ? -quo_nxt : quo_nxt;
    r_fin     = div_neg_r ? -rem_nxt : rem_nxt;
  end

  // control FSM with registered outputs; also tracks parser_done for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      pd_q      <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
      res_err   <= ERR_OK;
      busy      <= 1'b0;
      dtype_q   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
      div_dvs   <= '0;
      div_cnt   <= '0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
    end else begin
      pd_q <= parser_done;
      case (state)
        IDLE: begin
          // starts arriving in any other state are simply dropped
          if (start) begin
            dtype_q <= dtype;
            op_q    <= operator;
            a_q     <= src1;
            b_q     <= src2;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end

        EXEC: begin
          if (err_code != ERR_OK) begin
            result    <= '0;
            res_err   <= err_code;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (op_q == OP_DIV) begin
            div_rem   <= '0;
            div_quo   <= a_abs;
            div_dvs   <= b_abs;
            div_cnt   <= '0;
            div_neg_q <= a_neg ^ b_neg;
            div_neg_r <= a_neg;
            state     <= DIV;
          end else begin
            result    <= alu_res;
            res_err   <= ERR_OK;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DIV: begin
          div_rem <= rem_nxt;
          div_quo <= quo_nxt;
          div_cnt <= div_cnt + CW'(1);
          if (div_cnt == CW'(DW - 1)) begin
            result    <= {r_fin, q_fin};
            res_err   <= ERR_OK;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// tb/tb_calc_engine.sv - scoreboard bench for calc_engine with directed vectors
module tb_calc_engine;

  logic        clk;
  logic        n_rst;
  logic [3:0]  dtype;
  logic [4:0]  operator;
  logic [15:0] src1;
  logic [15:0] src2;
  logic        parser_done;
  logic        res_ready;
  logic        res_valid;
  logic [31:0] result;
  logic [1:0]  res_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];

  calc_engine #(.DW(16)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .dtype       (dtype),
    .operator    (operator),
    .src1        (src1),
    .src2        (src2),
    .parser_done (parser_done),
    .res_ready   (res_ready),
    .res_valid   (res_valid),
    .result      (result),
    .res_err     (res_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every accepted result is compared against the oldest expected entry
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (n_rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard unexpected: got %h/%0d expected none", result, res_err);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard result", result, e[31:0]);
          check("scoreboard err", {30'd0, res_err}, {30'd0, e[33:32]});
        end
      end
    end
  end

  // mode 0: normal pulse; 1: re-pulse during DIV then hold high; 2: hold high after handshake
  task automatic run(input logic [3:0] dt, input logic [4:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [31:0] er, input logic [1:0] ee,
                     input int elat, input int mode);
    int lat;
    bit got;
    exp_q.push_back({ee, er});
    @(negedge clk);
    dtype = dt; operator = op; src1 = a; src2 = b; parser_done = 1'b1;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) check("busy in exec", {31'd0, busy}, 32'd1);
      if (mode == 1 && lat == 4) begin
        parser_done = 1'b0; operator = 5'h01; src1 = 16'h0001; src2 = 16'h0001;
      end
      if (mode == 1 && lat == 5) parser_done = 1'b1;
      if (res_valid) got = 1;
    end
    check("latency", lat, elat);
    if (mode == 0) parser_done = 1'b0;
    for (int i = 0; i < 20 && res_valid; i++) @(negedge clk);
    check("valid drop", {31'd0, res_valid}, 32'd0);
    if (mode != 0) begin
      repeat (6) @(negedge clk);
      check("no second result", {31'd0, res_valid}, 32'd0);
      check("idle busy", {31'd0, busy}, 32'd0);
      parser_done = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_rst = 1'b0; dtype = '0; operator = '0; src1 = '0; src2 = '0;
    parser_done = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset valid", {31'd0, res_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset err", {30'd0, res_err}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    run(4'h2, 5'h01, 16'h0005, 16'h0003, 32'h00000008, 2'b00, 2, 0);
    run(4'h1, 5'h02, 16'h0003, 16'h0005, 32'hFFFFFFFE, 2'b00, 2, 0);
    run(4'h2, 5'h02, 16'h0003, 16'h0005, 32'hFFFFFFFE, 2'b00, 2, 0);
    run(4'h1, 5'h03, 16'hFFFE, 16'h0003, 32'hFFFFFFFA, 2'b00, 2, 0);
    run(4'h2, 5'h03, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 2'b00, 2, 0);
    run(4'h1, 5'h01, 16'h8000, 16'hFFFF, 32'hFFFF7FFF, 2'b00, 2, 0);
    run(4'h2, 5'h04, 16'h0064, 16'h0007, 32'h0002000E, 2'b00, 18, 0);
    run(4'h1, 5'h04, 16'hFFF9, 16'h0002, 32'hFFFFFFFD, 2'b00, 18, 0);
    run(4'h1, 5'h04, 16'h8000, 16'hFFFF, 32'h00008000, 2'b00, 18, 0);
    run(4'h1, 5'h04, 16'h0007, 16'hFFFE, 32'h0001FFFD, 2'b00, 18, 0);
    run(4'h2, 5'h04, 16'hFFFF, 16'h0001, 32'h0000FFFF, 2'b00, 18, 0);
    run(4'h2, 5'h04, 16'h0010, 16'h0000, 32'h00000000, 2'b01, 2, 0);
    run(4'h2, 5'h05, 16'h0010, 16'h0002, 32'h00000000, 2'b10, 2, 0);
    run(4'h1, 5'h00, 16'h0010, 16'h0002, 32'h00000000, 2'b10, 2, 0);
    run(4'h3, 5'h04, 16'h0010, 16'h0000, 32'h00000000, 2'b11, 2, 0);
    run(4'h0, 5'h01, 16'h0010, 16'h0002, 32'h00000000, 2'b11, 2, 0);

    // re-pulse during DIV is dropped, then parser_done stays high past the handshake
    run(4'h2, 5'h04, 16'h0064, 16'h0007, 32'h0002000E, 2'b00, 18, 1);
    run(4'h2, 5'h01, 16'h0002, 16'h0002, 32'h00000004, 2'b00, 2, 2);

    // back-pressure: result held stable while res_ready is low
    @(posedge clk); #1 res_ready = 1'b0;
    exp_q.push_back({2'b00, 32'h00000064});
    @(negedge clk);
    dtype = 4'h2; operator = 5'h03; src1 = 16'h000A; src2 = 16'h000A; parser_done = 1'b1;
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("hold latency", lat, 2);
    parser_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold valid", {31'd0, res_valid}, 32'd1);
      check("hold busy", {31'd0, busy}, 32'd1);
      check("hold result", result, 32'h00000064);
      check("hold err", {30'd0, res_err}, 32'd0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    for (int i = 0; i < 20 && (res_valid || i == 0); i++) @(negedge clk);
    check("hold release", {31'd0, res_valid}, 32'd0);

    // reset asserted mid-DIV aborts without a result
    @(negedge clk);
    dtype = 4'h1; operator = 5'h04; src1 = 16'hFFF9; src2 = 16'h0002; parser_done = 1'b1;
    repeat (5) @(negedge clk);
    check("div busy", {31'd0, busy}, 32'd1);
    n_rst = 1'b0;
    #1;
    check("abort valid", {31'd0, res_valid}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort err", {30'd0, res_err}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    parser_done = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    run(4'h2, 5'h01, 16'hFFFF, 16'h0001, 32'h00010000, 2'b00, 2, 0);

    repeat (3) @(negedge clk);
    check("scoreboard empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
